// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that shares one pipelined single-precision multiplier among NREQ
// requesters and routes each product back to its issuer via a tag pipe.
module fp_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 3,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*32-1:0]   op_a,
  input  logic [NREQ*32-1:0]   op_b,
  output logic [NREQ-1:0]      gnt,
  output logic [31:0]          mul_a,
  output logic [31:0]          mul_b,
  input  logic [31:0]          mul_c,
  output logic                 res_valid,
  output logic [IDW-1:0]       res_id,
  output logic [31:0]          res_data,
  output logic                 busy
);

  // Stage 0 lines up with the mul_a/mul_b register; the remaining MUL_LAT stages shadow
  // the multiplier's internal pipeline.
  localparam int Depth = MUL_LAT + 1;

  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             gv;
  logic [IDW-1:0]   gid;
  logic [Depth-1:0] tv_q;
  logic [IDW-1:0]   tid_q [Depth];

  // First requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    gnt = '0;
    gv  = 1'b0;
    gid = '0;
    idx = 0;
    if (!rst) begin
      for (int off = 0; off < NREQ; off++) begin
        idx = (int'(ptr_q) + off) % NREQ;
        if (!gv && req[idx]) begin
          gv  = 1'b1;
          gid = IDW'(idx);
        end
      end
    end
    if (gv) gnt[gid] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gv) begin
      if (int'(gid) == NREQ - 1) ptr_d = '0;
      else                        ptr_d = gid + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (gv) begin
        mul_a <= op_a[32*int'(gid) +: 32];
        mul_b <= op_b[32*int'(gid) +: 32];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= '0;
      for (int s = 0; s < Depth; s++) tid_q[s] <= '0;
    end else begin
      tv_q     <= {tv_q[Depth-2:0], gv};
      tid_q[0] <= gv ? gid : '0;
      for (int s = 1; s < Depth; s++) tid_q[s] <= tid_q[s-1];
    end
  end

  always_comb begin
    res_valid = tv_q[Depth-1];
    res_id    = tid_q[Depth-1];
    res_data  = tv_q[Depth-1] ? mul_c : 32'h0;
    busy      = |tv_q;
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: behavioural pipelined multiplier plus a queue-based
// scoreboard of issued operations, directed scenarios and randomized traffic.
module tb_fp_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int MUL_LAT = 3;
  localparam int IDW     = 2;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*32-1:0]  op_a;
  logic [NREQ*32-1:0]  op_b;
  logic [NREQ-1:0]     gnt;
  logic [31:0]         mul_a;
  logic [31:0]         mul_b;
  logic [31:0]         mul_c;
  logic                res_valid;
  logic [IDW-1:0]      res_id;
  logic [31:0]         res_data;
  logic                busy;

  fp_mul_arbiter #(
    .NREQ    (NREQ),
    .MUL_LAT (MUL_LAT),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_data  (res_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiply; denormals flush to zero.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          ea, eb, e;
    logic [47:0] p;
    logic [22:0] m;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
    if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0)) return 32'h7FC00000;
    if (ea == 255 || eb == 255) return {s, 8'hFF, 23'h0};
    if (ea == 0 || eb == 0) return {s, 31'h0};
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = ea + eb - 127;
    if (p[47]) begin
      m = p[46:24];
      e = e + 1;
    end else begin
      m = p[45:23];
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0) return {s, 31'h0};
    return {s, 8'(e), m};
  endfunction

  // Multiplier model: product of mul_a/mul_b appears MUL_LAT edges later.
  logic [31:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    mpipe[0] <= fmul(mul_a, mul_b);
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign mul_c = mpipe[MUL_LAT-1];

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          ptr_m;
  logic [31:0] exp_ma, exp_mb;
  int          cyc;
  int          checks;
  int          failures;

  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int off = 0; off < NREQ; off++) begin
      if (r[(p + off) % NREQ]) return (p + off) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] exp_gnt();
    int g;
    if (rst) return '0;
    g = model_pick(req, ptr_m);
    if (g < 0) return '0;
    return NREQ'(1 << g);
  endfunction

  function automatic logic exp_valid();
    return q.size() > 0 && q[0].due == cyc;
  endfunction

  // Advance the reference model across one rising edge, then the clock itself.
  task automatic tick();
    int   g;
    exp_t e;
    if (q.size() > 0 && q[0].due == cyc) void'(q.pop_front());
    if (rst) begin
      q.delete();
      ptr_m  = 0;
      exp_ma = '0;
      exp_mb = '0;
    end else begin
      g = model_pick(req, ptr_m);
      if (g >= 0) begin
        e.id   = g;
        e.data = fmul(op_a[32*g +: 32], op_b[32*g +: 32]);
        e.due  = cyc + 1 + MUL_LAT;
        q.push_back(e);
        ptr_m  = (g + 1) % NREQ;
        exp_ma = op_a[32*g +: 32];
        exp_mb = op_b[32*g +: 32];
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req = '0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = '1;
    op_a = {NREQ{32'h3F800000}};
    op_b = {NREQ{32'h40000000}};
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (gnt !== '0) begin
      failures++;
      $display("FAIL reset_gnt got=%b exp=0", gnt);
    end
    checks++;
    if (mul_a !== 32'h0 || mul_b !== 32'h0) begin
      failures++;
      $display("FAIL reset_mul got=%h/%h exp=0/0", mul_a, mul_b);
    end
    checks++;
    if (res_valid !== 1'b0 || res_id !== '0 || res_data !== 32'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_res got v=%b id=%0d d=%h busy=%b exp 0", res_valid, res_id,
               res_data, busy);
    end
    tick();
    rst = 1'b0;
    req = '0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    op_a[31:0] = 32'h40000000;
    op_b[31:0] = 32'h42000000;
    req = 4'b0001;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== (n == 0 ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL single_gnt n=%0d got=%b", n, gnt);
      end
      checks++;
      if (res_valid !== (n == MUL_LAT + 1)) begin
        failures++;
        $display("FAIL single_valid n=%0d got=%b exp=%b", n, res_valid, n == MUL_LAT + 1);
      end
      if (n == MUL_LAT + 1) begin
        checks++;
        if (res_id !== 2'd0 || res_data !== 32'h42800000) begin
          failures++;
          $display("FAIL single_res got id=%0d d=%h exp id=0 d=42800000", res_id, res_data);
        end
      end
      tick();
      req = '0;
    end
  endtask

  task automatic test_round_robin();
    int id;
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[32*i +: 32] = 32'h3F800000 + 32'(i << 20);
      op_b[32*i +: 32] = 32'h40400000 + 32'(i << 18);
    end
    req = '1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== NREQ'(1 << (n % NREQ))) begin
        failures++;
        $display("FAIL rr_gnt n=%0d got=%b exp=%b", n, gnt, NREQ'(1 << (n % NREQ)));
      end
      checks++;
      if (res_valid !== (n >= MUL_LAT + 1)) begin
        failures++;
        $display("FAIL rr_valid n=%0d got=%b", n, res_valid);
      end
      if (n >= MUL_LAT + 1) begin
        id = (n - MUL_LAT - 1) % NREQ;
        checks++;
        if (res_id !== IDW'(id) || res_data !== fmul(op_a[32*id +: 32], op_b[32*id +: 32]))
        begin
          failures++;
          $display("FAIL rr_res n=%0d got id=%0d d=%h exp id=%0d d=%h", n, res_id, res_data,
                   id, fmul(op_a[32*id +: 32], op_b[32*id +: 32]));
        end
      end
      tick();
    end
    idle(MUL_LAT + 2);
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0010;
    tick();
    req = 4'b1011;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (gnt !== (n == 0 ? 4'b1000 : (n == 1 ? 4'b0001 : 4'b0010))) begin
        failures++;
        $display("FAIL collision_gnt n=%0d got=%b", n, gnt);
      end
      tick();
    end
    idle(MUL_LAT + 2);
  endtask

  task automatic test_specials();
    bit seen1, seen2;
    seen1 = 1'b0;
    seen2 = 1'b0;
    op_a[63:32] = 32'h7F800000;
    op_b[63:32] = 32'h01810000;
    op_a[95:64] = 32'h00000000;
    op_b[95:64] = 32'h7F800000;
    req = 4'b0010;
    tick();
    req = 4'b0100;
    tick();
    req = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (res_valid && res_id == 2'd1) begin
        seen1 = 1'b1;
        checks++;
        if (res_data !== 32'h7F800000) begin
          failures++;
          $display("FAIL special_inf got=%h exp=7f800000", res_data);
        end
      end
      if (res_valid && res_id == 2'd2) begin
        seen2 = 1'b1;
        checks++;
        if (res_data[30:23] !== 8'hFF || res_data[22:0] == 23'h0) begin
          failures++;
          $display("FAIL special_nan got=%h exp=NaN", res_data);
        end
      end
      tick();
    end
    checks++;
    if (!seen1 || !seen2) begin
      failures++;
      $display("FAIL special_seen got=%b%b exp=11", seen1, seen2);
    end
  endtask

  task automatic test_reset_flight();
    int nvalid;
    nvalid = 0;
    req = 4'b0111;
    for (int n = 0; n < 3; n++) tick();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL flight_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    req = 4'b1000;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL flight_rst_gnt got=%b exp=0000", gnt);
    end
    if (res_valid) nvalid++;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL flight_post_gnt got=%b exp=1000", gnt);
    end
    if (res_valid) nvalid++;
    tick();
    req = '0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (res_valid) begin
        nvalid++;
        checks++;
        if (res_id !== 2'd3) begin
          failures++;
          $display("FAIL flight_id got=%0d exp=3", res_id);
        end
      end
      tick();
    end
    checks++;
    if (nvalid != 1) begin
      failures++;
      $display("FAIL flight_count got=%0d exp=1", nvalid);
    end
  endtask

  task automatic test_idle();
    op_a[31:0] = 32'h40A00000;
    op_b[31:0] = 32'h3F000000;
    req = 4'b0001;
    tick();
    req = '0;
    for (int n = 0; n < 10; n++) begin
      op_a = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      checks++;
      if (gnt !== '0 || mul_a !== 32'h40A00000 || mul_b !== 32'h3F000000) begin
        failures++;
        $display("FAIL idle_hold n=%0d got gnt=%b a=%h b=%h", n, gnt, mul_a, mul_b);
      end
      checks++;
      if (busy !== (n < MUL_LAT + 1)) begin
        failures++;
        $display("FAIL idle_busy n=%0d got=%b exp=%b", n, busy, n < MUL_LAT + 1);
      end
      checks++;
      if (res_valid !== (n == MUL_LAT)) begin
        failures++;
        $display("FAIL idle_valid n=%0d got=%b exp=%b", n, res_valid, n == MUL_LAT);
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      req = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        op_a[32*i +: 32] = $urandom;
        op_b[32*i +: 32] = $urandom;
      end
      @(negedge clk);
      checks++;
      if (gnt !== exp_gnt()) begin
        failures++;
        $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, gnt, exp_gnt());
      end
      checks++;
      if (res_valid !== exp_valid()) begin
        failures++;
        $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, res_valid, exp_valid());
      end
      if (exp_valid()) begin
        checks++;
        if (res_id !== IDW'(q[0].id) || res_data !== q[0].data) begin
          failures++;
          $display("FAIL rand_res cyc=%0d got id=%0d d=%h exp id=%0d d=%h", cyc, res_id,
                   res_data, q[0].id, q[0].data);
        end
      end
      checks++;
      if (busy !== (q.size() > 0)) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, busy, q.size() > 0);
      end
      checks++;
      if (mul_a !== exp_ma || mul_b !== exp_mb) begin
        failures++;
        $display("FAIL rand_mul cyc=%0d got=%h/%h exp=%h/%h", cyc, mul_a, mul_b, exp_ma,
                 exp_mb);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    ptr_m    = 0;
    exp_ma   = '0;
    exp_mb   = '0;
    rst      = 1'b1;
    req      = '0;
    op_a     = '0;
    op_b     = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_specials();
    test_reset_flight();
    test_idle();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
